bcd_formatter: RTL and testbench

BCD_FORMATTER -- requirements
Module: bcd_formatter

---
 rtl/bcd_formatter_pkg.sv | 15 +
 rtl/bcd_formatter_if.sv | 29 ++
 rtl/bcd_formatter_add3.sv | 11 +
 rtl/bcd_formatter.sv | 128 ++++++++++++
 tb/tb_bcd_formatter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_formatter_pkg.sv
// Shared types and constants for the binary-to-BCD display formatter.
package bcd_pkg;

    localparam int DIGITS = 8;
    localparam int unsigned MAX_VALUE = 99_999_999;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_t;

    typedef logic [DIGITS-1:0][3:0] bcd_digits_t;

endpackage

// File: rtl/bcd_formatter_if.sv
// Request/result bundle between a producer of binary values and the BCD formatter.
interface bcd_formatter_if
    import bcd_pkg::*;
#(
    parameter int WIDTH = 27
) ();

    logic             start;
    logic [WIDTH-1:0] value;
    logic             dp_en;
    logic [2:0]       dp_pos;
    logic             busy;
    logic             done;
    logic             overflow;
    bcd_digits_t      display;
    logic [7:0]       en;
    logic [7:0]       dots;

    modport master (
        output start, value, dp_en, dp_pos,
        input  busy, done, overflow, display, en, dots
    );

    modport slave (
        input  start, value, dp_en, dp_pos,
        output busy, done, overflow, display, en, dots
    );

endinterface

// File: rtl/bcd_formatter_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = (din >= 4'd5) ? din + 4'd3 : din;
    end

endmodule

// File: rtl/bcd_formatter.sv
// Sequential double-dabble converter driving an 8-digit BCD screen.
// Define BCD_FORMATTER_LZB_EN to compile in leading-zero blanking of the digit enables.
module bcd_formatter
    import bcd_pkg::*;
#(
    parameter int WIDTH = 27
) (
    input logic            clock,
    input logic            rst,
    bcd_formatter_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] bin;
    bcd_digits_t      bcd;
    bcd_digits_t      result;
    logic [31:0]      adj;
    logic [CW-1:0]    cnt;
    logic             dp_en_q;
    logic [2:0]       dp_pos_q;
    logic             ovf_q;

    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_add3
            bcd_add3 u_add3 (
                .din  (bcd[i]),
                .dout (adj[4*i +: 4])
            );
        end
    endgenerate

`ifdef BCD_FORMATTER_LZB_EN
    // Once a digit is lit, every less significant digit must stay lit as well.
    function automatic logic [7:0] digit_enables(input bcd_digits_t d, input logic dp_on,
                                                 input logic [2:0] pos);
        logic [7:0] mask;
        logic       lit;
        mask = 8'h00;
        lit  = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lit     = lit | (d[k] != 4'd0) | (k == 0) | (dp_on && (k <= int'(pos)));
            mask[k] = lit;
        end
        return mask;
    endfunction
`else
    assign bus.en = 8'hFF;
`endif

    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_next = LOAD;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != IDLE);
    end

    assign result = ovf_q ? {DIGITS{4'd9}} : bcd;

    // Visible outputs only change in LOAD, so the screen never shows a partial conversion.
    always_ff @(posedge clock) begin
        if (rst) begin
            bin          <= '0;
            bcd          <= '0;
            cnt          <= '0;
            dp_en_q      <= 1'b0;
            dp_pos_q     <= 3'd0;
            ovf_q        <= 1'b0;
            bus.done     <= 1'b0;
            bus.overflow <= 1'b0;
            bus.display  <= '0;
            bus.dots     <= 8'h00;
`ifdef BCD_FORMATTER_LZB_EN
            bus.en       <= 8'h01;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bin      <= bus.value;
                        bcd      <= '0;
                        cnt      <= CW'(WIDTH);
                        dp_en_q  <= bus.dp_en;
                        dp_pos_q <= bus.dp_pos;
                        ovf_q    <= (32'(bus.value) > MAX_VALUE);
                    end
                end
                SHIFT: begin
                    // A carry out of the top digit also means the value did not fit.
                    bcd   <= {adj[30:0], bin[WIDTH-1]};
                    bin   <= bin << 1;
                    cnt   <= cnt - CW'(1);
                    ovf_q <= ovf_q | adj[31];
                end
                LOAD: begin
                    bus.done     <= 1'b1;
                    bus.overflow <= ovf_q;
                    bus.display  <= result;
                    bus.dots     <= dp_en_q ? (8'h01 << dp_pos_q) : 8'h00;
`ifdef BCD_FORMATTER_LZB_EN
                    bus.en       <= digit_enables(result, dp_en_q, dp_pos_q);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_formatter.sv
// Self-checking bench for bcd_formatter: decimal reference model plus directed literal checks.
// Builds with or without BCD_FORMATTER_LZB_EN.
module tb_bcd_formatter;
    import bcd_pkg::*;

    localparam int WIDTH = 27;
`ifdef BCD_FORMATTER_LZB_EN
    localparam logic [7:0] EN_RST = 8'h01;
`else
    localparam logic [7:0] EN_RST = 8'hFF;
`endif

    logic clock = 1'b0;
    logic rst;
    logic chk_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    bcd_formatter_if #(.WIDTH(WIDTH)) bus ();

    bcd_formatter #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int          m_cnt;
    longint      m_val;
    logic        m_dpen;
    logic [2:0]  m_dppos;
    logic [31:0] exp_display;
    logic [7:0]  exp_en;
    logic [7:0]  exp_dots;
    logic        exp_ovf;
    logic        exp_done;

    function automatic logic [31:0] model_digits(input longint v);
        logic [31:0] d;
        d = 32'h0;
        if (v > 64'd99_999_999) return 32'h9999_9999;
        for (int k = 0; k < 8; k++) begin
            d[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return d;
    endfunction

`ifdef BCD_FORMATTER_LZB_EN
    function automatic logic [7:0] model_en(input logic [31:0] disp, input logic dpen,
                                            input logic [2:0] pos);
        int         top;
        logic [7:0] m;
        top = 0;
        for (int k = 0; k < 8; k++) if (disp[4*k +: 4] != 4'd0) top = k;
        if (dpen && int'(pos) > top) top = int'(pos);
        m = 8'h00;
        for (int k = 0; k <= top; k++) m[k] = 1'b1;
        return m;
    endfunction
`endif

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a conversion takes WIDTH+1 edges after the start edge, then results appear.
    always @(posedge clock) begin
        if (rst) begin
            m_cnt       = 0;
            exp_done    = 1'b0;
            exp_display = 32'h0;
            exp_en      = EN_RST;
            exp_dots    = 8'h00;
            exp_ovf     = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (m_cnt == 0) begin
                if (bus.start) begin
                    m_val   = longint'(bus.value);
                    m_dpen  = bus.dp_en;
                    m_dppos = bus.dp_pos;
                    m_cnt   = WIDTH + 1;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    exp_ovf     = (m_val > 64'd99_999_999);
                    exp_display = model_digits(m_val);
                    exp_dots    = m_dpen ? (8'h01 << m_dppos) : 8'h00;
`ifdef BCD_FORMATTER_LZB_EN
                    exp_en      = model_en(exp_display, m_dpen, m_dppos);
`else
                    exp_en      = 8'hFF;
`endif
                    exp_done    = 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            checkOutput("busy", 32'(bus.busy), 32'(m_cnt != 0));
            checkOutput("done", 32'(bus.done), 32'(exp_done));
            checkOutput("overflow", 32'(bus.overflow), 32'(exp_ovf));
            checkOutput("display", bus.display, exp_display);
            checkOutput("en", 32'(bus.en), 32'(exp_en));
            checkOutput("dots", 32'(bus.dots), 32'(exp_dots));
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] v, input logic dpen, input logic [2:0] pos);
        bus.value  = v;
        bus.dp_en  = dpen;
        bus.dp_pos = pos;
        bus.start  = 1'b1;
        @(posedge clock);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < WIDTH + 20) begin
            @(posedge clock);
            #1;
            lat++;
            if (bus.done) break;
        end
        checkOutput("done_seen", 32'(bus.done), 32'd1);
    endtask

    int unsigned tv[6] = '{9, 10, 99_999_999, 134_217_727, 1000, 80_808_080};

    initial begin
        int lat;
        int pulses;

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.value  = '0;
        bus.dp_en  = 1'b0;
        bus.dp_pos = 3'd0;
        @(posedge clock);
        #1 chk_en = 1'b1;
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_display", bus.display, 32'h0);
        checkOutput("rst_en", 32'(bus.en), 32'(EN_RST));
        checkOutput("rst_dots", 32'(bus.dots), 32'h0);
        repeat (2) @(posedge clock);
        #1 rst = 1'b0;

        // Value changed right after the start edge must not disturb the conversion.
        applyStimulus(27'd12_345_678, 1'b0, 3'd0);
        bus.value = 27'd99;
        wait_done(lat);
        checkOutput("latency", 32'(lat), 32'(WIDTH + 1));
        checkOutput("t1_display", bus.display, 32'h1234_5678);
        checkOutput("t1_en", 32'(bus.en), 32'hFF);
        checkOutput("t1_ovf", 32'(bus.overflow), 32'd0);

        applyStimulus(27'd0, 1'b0, 3'd0);
        wait_done(lat);
        checkOutput("zero_display", bus.display, 32'h0);
        checkOutput("zero_en", 32'(bus.en), 32'(EN_RST));
        checkOutput("zero_dots", 32'(bus.dots), 32'h0);

        applyStimulus(27'd305, 1'b1, 3'd2);
        wait_done(lat);
        checkOutput("dp_display", bus.display, 32'h0000_0305);
        checkOutput("dp_dots", 32'(bus.dots), 32'h04);
`ifdef BCD_FORMATTER_LZB_EN
        checkOutput("dp_en", 32'(bus.en), 32'h07);
`else
        checkOutput("dp_en", 32'(bus.en), 32'hFF);
`endif

        applyStimulus(27'd100_000_000, 1'b0, 3'd0);
        wait_done(lat);
        checkOutput("ovf_flag", 32'(bus.overflow), 32'd1);
        checkOutput("ovf_display", bus.display, 32'h9999_9999);
        applyStimulus(27'd7, 1'b0, 3'd0);
        wait_done(lat);
        checkOutput("after_ovf_flag", 32'(bus.overflow), 32'd0);
        checkOutput("after_ovf_display", bus.display, 32'h7);

        for (int k = 0; k < 6; k++) begin
            applyStimulus(27'(tv[k]), 1'(k % 2), 3'((k + 3) % 8));
            wait_done(lat);
        end

        // Start pulsed mid-conversion is dropped.
        applyStimulus(27'd555, 1'b0, 3'd0);
        repeat (4) @(posedge clock);
        #1 bus.value = 27'd777;
        bus.start = 1'b1;
        @(posedge clock);
        #1 bus.start = 1'b0;
        pulses = 0;
        for (int k = 0; k < 2 * WIDTH; k++) begin
            @(posedge clock);
            #1 if (bus.done) pulses++;
        end
        checkOutput("one_done", 32'(pulses), 32'd1);
        checkOutput("hs_display", bus.display, 32'h555);

        // Reset during the tenth SHIFT cycle aborts the conversion.
        applyStimulus(27'd4321, 1'b1, 3'd3);
        repeat (9) @(posedge clock);
        #1 rst = 1'b1;
        @(posedge clock);
        #1 rst = 1'b0;
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_display", bus.display, 32'h0);
        checkOutput("abort_dots", 32'(bus.dots), 32'h0);
        checkOutput("abort_en", 32'(bus.en), 32'(EN_RST));
        pulses = 0;
        for (int k = 0; k < WIDTH + 5; k++) begin
            @(posedge clock);
            #1 if (bus.done) pulses++;
        end
        checkOutput("abort_no_done", 32'(pulses), 32'd0);

        // Start held high retriggers straight from IDLE.
        bus.value  = 27'd42;
        bus.dp_en  = 1'b0;
        bus.start  = 1'b1;
        wait_done(lat);
        checkOutput("b2b_first_lat", 32'(lat), 32'(WIDTH + 2));
        checkOutput("b2b_first_display", bus.display, 32'h42);
        bus.value = 27'd43;
        wait_done(lat);
        bus.start = 1'b0;
        checkOutput("b2b_second_lat", 32'(lat), 32'(WIDTH + 2));
        checkOutput("b2b_second_display", bus.display, 32'h43);

        repeat (WIDTH + 4) @(posedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
